regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised successor to the single-write-port 32x64 regfile.
- Configurable width, depth and number of combinational read ports.
- Two clocked write ports with defined conflict priority, and an optional same-cycle write-to-read bypass.
- A per-register busy scoreboard, so the datapath can stall reads of registers that have an outstanding multi-cycle load.
- Sits in the decode stage: reads feed the ALU operand muxes; writes come from writeback (ALU) and the load unit.

Parameters:
- W, 64, data width in bits.
- N, 32, number of registers; a power of 2, minimum 4.
- AW, $clog2(N), address width; derived, not to be overridden.
- NRD, 2, number of read ports, 1..4.
- ZR_EN, 1, 1 makes register N-1 a hard zero register (XZR).
- BYPASS, 0, 1 makes a read of a register being written this cycle return the incoming write data.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- we3  in  1  write enable, port A (ALU writeback).
- wa3  in  AW  write address, port A.
- wd3  in  W  write data, port A.
- we4  in  1  write enable, port B (load return).
- wa4  in  AW  write address, port B.
- wd4  in  W  write data, port B.
- rsv_en  in  1  mark register rsv_addr busy (load issued).
- rsv_addr  in  AW  register to reserve.
- ra  in  NRD*AW  read addresses; port k is ra[k*AW +: AW].
- rd  out  NRD*W  read data; port k is rd[k*W +: W].
- busy  out  NRD  busy flag of the register addressed by each read port.

Behaviour:
- Reset (asynchronous, active-high):
  - Register i loads i (zero-extended to W).
  - Register N-1 loads 0 when ZR_EN=1.
  - All busy bits clear.
  - rd and busy follow combinationally from these values: while reset is asserted, rd[k] = ra[k] (or 0 for ZR) and busy = 0.
- Reset mid-operation: aborts pending reservations; every busy bit is 0 immediately, without waiting for a clock edge.
- Writes:
  - Take effect on the rising edge of clk when the corresponding we is high.
  - Same address on both ports in the same cycle: port B (wd4) wins.
  - Different addresses: both writes commit.
- Zero register (ZR_EN=1):
  - Writes to N-1 are ignored.
  - Reads of N-1 return 0 and busy=0.
  - rsv_en to N-1 is ignored.
- Reads:
  - Combinational, zero cycles.
  - BYPASS=0: the new value is visible only after the edge.
  - BYPASS=1: a read address matching an active write returns the write data in the same cycle, with port B taking priority. Never applies to ZR.
- Scoreboard (one bit per register):
  - Set at the edge when rsv_en=1.
  - Cleared at the edge by we4 to that register. we3 does not clear it.
  - rsv_en and we4 to the same register in the same cycle: the bit stays set (the new load supersedes the old).
  - Reserving an already-busy register is legal; the bit stays set.
  - BYPASS=1: busy is combinationally cleared for a read address matching an active we4 write, unless rsv_en targets the same address.
- Width rules: no arithmetic. Addresses at or above N cannot occur because N = 2^AW.

Decomposition:
- Package regfile_pkg:
  - Default W and N.
  - Typedefs reg_addr_t and reg_data_t.
  - Constant XZR = N-1.
- One sub-module: regfile_scoreboard, holding the busy vector, reservation/clear logic and busy lookup per read port.
- Storage, write priority and bypass muxing stay in regfile_mp.

Test Plan:
- Reset, then read all 32 registers on ra0/ra1 with no writes -> rd = index value, reg 31 reads 0, busy = 0 everywhere.
- we3=1, wa3=0, wd3=255 for one cycle while ra0=0, ra1=25 -> BYPASS=0: rd0=0 in the write cycle, 255 after the edge; rd1=25 throughout. BYPASS=1: rd0=255 in the write cycle.
- we3 to reg 31 with wd3=0xc0c0, then 0xc4c4 -> rd for reg 31 stays 0.
- Same cycle: we3 (wa3=5, wd3=0xAA) and we4 (wa4=5, wd4=0xBB) -> reg 5 reads 0xBB; repeat with wa3=5, wa4=6 -> 0xAA and 0xBB.
- rsv_en on reg 7 -> busy=1 next cycle; we3 to 7 -> still busy; we4 to 7 with 0x1234 -> busy=0 and rd=0x1234; rsv_en and we4 to 7 in the same cycle -> busy remains 1.
- Reserve regs 3 and 9, then assert reset between clock edges -> busy drops to 0 immediately, reg 3 reads 3, reg 9 reads 9.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and types for the multi-port register file.
// The zero register sits at the top index.
package regfile_pkg;
   localparam int W_DEF  = 64;
   localparam int N_DEF  = 32;
   localparam int AW_DEF = $clog2(N_DEF);
   localparam int XZR    = N_DEF - 1;

   typedef logic [AW_DEF-1:0] reg_addr_t;
   typedef logic [W_DEF-1:0]  reg_data_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits for outstanding loads.
// Set by a reservation and cleared by a load-return write.
module regfile_scoreboard #(
   parameter  int N      = 32,
   parameter  int NRD    = 2,
   parameter  int ZR_EN  = 1,
   parameter  int BYPASS = 0,
   localparam int AW     = $clog2(N)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we4,
   input  logic [AW-1:0]     wa4,
   input  logic              rsv_en,
   input  logic [AW-1:0]     rsv_addr,
   input  logic [NRD*AW-1:0] ra,
   output logic [NRD-1:0]    busy
);
   logic [N-1:0] busy_q;
   logic [N-1:0] busy_d;

   // The set is applied after the clear: a new load supersedes the returning one.
   always_comb begin
      busy_d = busy_q;
      for (int i = 0; i < N; i++) begin
         if (we4 && wa4 == AW'(i))
            busy_d[i] = 1'b0;
         if (rsv_en && rsv_addr == AW'(i))
            busy_d[i] = 1'b1;
         if (ZR_EN != 0 && i == N - 1)
            busy_d[i] = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         busy_q <= '0;
      else
         busy_q <= busy_d;
   end

   genvar gi;
   generate
      for (gi = 0; gi < NRD; gi++) begin : g_lookup
         logic [AW-1:0] addr;
         logic          ret_hit;
         assign addr    = ra[gi*AW +: AW];
         assign ret_hit = (BYPASS != 0) && we4 && (wa4 == addr) &&
                          !(rsv_en && rsv_addr == addr);
         assign busy[gi] = busy_q[addr] & ~ret_hit;
      end
   endgenerate
endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: two write ports (load port wins on collision),
// NRD combinational read ports, optional write bypass and a busy scoreboard.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter  int W      = W_DEF,
   parameter  int N      = N_DEF,
   parameter  int NRD    = 2,
   parameter  int ZR_EN  = 1,
   parameter  int BYPASS = 0,
   localparam int AW     = $clog2(N)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we3,
   input  logic [AW-1:0]     wa3,
   input  logic [W-1:0]      wd3,
   input  logic              we4,
   input  logic [AW-1:0]     wa4,
   input  logic [W-1:0]      wd4,
   input  logic              rsv_en,
   input  logic [AW-1:0]     rsv_addr,
   input  logic [NRD*AW-1:0] ra,
   output logic [NRD*W-1:0]  rd,
   output logic [NRD-1:0]    busy
);
   logic [W-1:0] mem_q [N];
   logic [W-1:0] mem_d [N];

   always_comb begin
      for (int i = 0; i < N; i++) begin
         mem_d[i] = mem_q[i];
         if (we3 && wa3 == AW'(i))
            mem_d[i] = wd3;
         if (we4 && wa4 == AW'(i))
            mem_d[i] = wd4;
         if (ZR_EN != 0 && i == N - 1)
            mem_d[i] = '0;
      end
   end

   // Each register resets to its own index so reset contents are recognisable.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N; i++)
            mem_q[i] <= (ZR_EN != 0 && i == N - 1) ? '0 : W'(i);
      end else begin
         for (int i = 0; i < N; i++)
            mem_q[i] <= mem_d[i];
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NRD; gi++) begin : g_read
         logic [AW-1:0] addr;
         logic [W-1:0]  data;
         assign addr = ra[gi*AW +: AW];
         always_comb begin
            data = mem_q[addr];
            if (BYPASS != 0 && !reset) begin
               if (we3 && wa3 == addr)
                  data = wd3;
               if (we4 && wa4 == addr)
                  data = wd4;
            end
            if (ZR_EN != 0 && addr == AW'(N - 1))
               data = '0;
         end
         assign rd[gi*W +: W] = data;
      end
   endgenerate

   regfile_scoreboard #(
      .N      (N),
      .NRD    (NRD),
      .ZR_EN  (ZR_EN),
      .BYPASS (BYPASS)
   ) u_scoreboard (
      .clk      (clk),
      .reset    (reset),
      .we4      (we4),
      .wa4      (wa4),
      .rsv_en   (rsv_en),
      .rsv_addr (rsv_addr),
      .ra       (ra),
      .busy     (busy)
   );
endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a non-bypass and a bypass instance share stimulus and
// are checked against an array model, a directed table and random traffic.
module tb_regfile_mp;
   import regfile_pkg::*;

   localparam int W   = W_DEF;
   localparam int N   = N_DEF;
   localparam int AW  = $clog2(N);
   localparam int NRD = 2;

   logic              clk = 1'b0;
   logic              reset;
   logic              we3, we4, rsv_en;
   logic [AW-1:0]     wa3, wa4, rsv_addr;
   logic [W-1:0]      wd3, wd4;
   logic [NRD*AW-1:0] ra;
   logic [NRD*W-1:0]  rd_nb, rd_bp;
   logic [NRD-1:0]    busy_nb, busy_bp;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   regfile_mp #(.W(W), .N(N), .NRD(NRD), .ZR_EN(1), .BYPASS(0)) u_dut (
      .clk(clk), .reset(reset),
      .we3(we3), .wa3(wa3), .wd3(wd3),
      .we4(we4), .wa4(wa4), .wd4(wd4),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr),
      .ra(ra), .rd(rd_nb), .busy(busy_nb)
   );

   regfile_mp #(.W(W), .N(N), .NRD(NRD), .ZR_EN(1), .BYPASS(1)) u_dut_bp (
      .clk(clk), .reset(reset),
      .we3(we3), .wa3(wa3), .wd3(wd3),
      .we4(we4), .wa4(wa4), .wd4(wd4),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr),
      .ra(ra), .rd(rd_bp), .busy(busy_bp)
   );

   // Reference model: architectural register contents and busy flags.
   logic [W-1:0] m_mem  [N];
   bit           m_busy [N];

   function automatic void model_reset();
      for (int i = 0; i < N; i++) begin
         m_mem[i]  = (i == XZR) ? '0 : W'(i);
         m_busy[i] = 1'b0;
      end
   endfunction

   function automatic void model_edge();
      if (we3 && int'(wa3) != XZR) m_mem[wa3] = wd3;
      if (we4 && int'(wa4) != XZR) m_mem[wa4] = wd4;
      if (we4) m_busy[wa4] = 1'b0;
      if (rsv_en && int'(rsv_addr) != XZR) m_busy[rsv_addr] = 1'b1;
   endfunction

   function automatic logic [W-1:0] exp_rd(input int a, input bit bp);
      logic [W-1:0] v;
      if (a == XZR) return '0;
      v = m_mem[a];
      if (bp && !reset) begin
         if (we3 && int'(wa3) == a) v = wd3;
         if (we4 && int'(wa4) == a) v = wd4;
      end
      return v;
   endfunction

   function automatic bit exp_busy(input int a, input bit bp);
      bit b;
      if (a == XZR || reset) return 1'b0;
      b = m_busy[a];
      if (bp && we4 && int'(wa4) == a && !(rsv_en && int'(rsv_addr) == a)) b = 1'b0;
      return b;
   endfunction

   function automatic void check(input string name, input logic [W-1:0] got, input logic [W-1:0] req);
      n_checks++;
      if (got !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, req);
      end
   endfunction

   function automatic void check_all(input string tag);
      for (int k = 0; k < NRD; k++) begin
         int a;
         a = int'(ra[k*AW +: AW]);
         check($sformatf("%s rd%0d a=%0d", tag, k, a), rd_nb[k*W +: W], exp_rd(a, 1'b0));
         check($sformatf("%s rd_bp%0d a=%0d", tag, k, a), rd_bp[k*W +: W], exp_rd(a, 1'b1));
         check($sformatf("%s busy%0d a=%0d", tag, k, a), W'(busy_nb[k]), W'(exp_busy(a, 1'b0)));
         check($sformatf("%s busy_bp%0d a=%0d", tag, k, a), W'(busy_bp[k]), W'(exp_busy(a, 1'b1)));
      end
   endfunction

   task automatic set_ra(input int a0, input int a1);
      ra = {AW'(a1), AW'(a0)};
   endtask

   task automatic idle();
      we3 = 0; wa3 = '0; wd3 = '0;
      we4 = 0; wa4 = '0; wd4 = '0;
      rsv_en = 0; rsv_addr = '0;
   endtask

   // Entered at posedge+1 with inputs driven; checks pre-edge, then clocks the model.
   task automatic cycle(input string tag);
      #2;
      check_all(tag);
      @(posedge clk);
      if (!reset) model_edge();
      #1;
   endtask

   function automatic int rnd_addr();
      int p;
      p = $urandom_range(0, 7);
      if (p == 0) return XZR;
      if (p < 3) return $urandom_range(5, 7);
      return $urandom_range(0, N - 1);
   endfunction

   typedef struct {
      logic          we3;
      logic [AW-1:0] wa3;
      logic [W-1:0]  wd3;
      logic          we4;
      logic [AW-1:0] wa4;
      logic [W-1:0]  wd4;
      logic          rsv;
      logic [AW-1:0] rsv_a;
      logic [AW-1:0] r0, r1;
      logic [W-1:0]  e0, e1;
      logic [1:0]    eb;
   } vec_t;

   function automatic vec_t mk(input int w3, input int a3, input longint d3,
                               input int w4, input int a4, input longint d4,
                               input int rs, input int rsa, input int r0, input int r1,
                               input longint e0, input longint e1, input int eb);
      vec_t v;
      v.we3 = 1'(w3);  v.wa3 = AW'(a3); v.wd3 = W'(d3);
      v.we4 = 1'(w4);  v.wa4 = AW'(a4); v.wd4 = W'(d4);
      v.rsv = 1'(rs);  v.rsv_a = AW'(rsa);
      v.r0 = AW'(r0);  v.r1 = AW'(r1);
      v.e0 = W'(e0);   v.e1 = W'(e1);   v.eb = 2'(eb);
      return v;
   endfunction

   vec_t vt [11];

   initial begin
      // Expected values are the post-edge reads, derived by hand from the rules.
      vt[0]  = mk(1,  0, 255,    0, 0, 0,      0,  0,  0, 25, 255,    25,     0);
      vt[1]  = mk(1, 31, 'hc0c0, 0, 0, 0,      0,  0, 31,  0, 0,      255,    0);
      vt[2]  = mk(1, 31, 'hc4c4, 0, 0, 0,      0,  0, 31,  1, 0,      1,      0);
      vt[3]  = mk(1,  5, 'hAA,   1, 5, 'hBB,   0,  0,  5,  6, 'hBB,   6,      0);
      vt[4]  = mk(1,  5, 'hAA,   1, 6, 'hBB,   0,  0,  5,  6, 'hAA,   'hBB,   0);
      vt[5]  = mk(0,  0, 0,      0, 0, 0,      1,  7,  7,  5, 7,      'hAA,   1);
      vt[6]  = mk(1,  7, 'h77,   0, 0, 0,      0,  0,  7,  7, 'h77,   'h77,   3);
      vt[7]  = mk(0,  0, 0,      1, 7, 'h1234, 0,  0,  7,  6, 'h1234, 'hBB,   0);
      vt[8]  = mk(0,  0, 0,      1, 7, 'h5678, 1,  7,  7, 31, 'h5678, 0,      1);
      vt[9]  = mk(1, 31, 'hdead, 0, 0, 0,      1, 31, 31,  7, 0,      'h5678, 2);
      vt[10] = mk(0,  0, 0,      1, 7, 'h9,    0,  0,  0,  7, 255,    9,      0);

      idle();
      reset = 1'b1;
      set_ra(4, XZR);
      model_reset();
      #2;
      check_all("in_reset");
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Reset contents on every register, both ports.
      for (int i = 0; i < N; i++) begin
         set_ra(i, N - 1 - i);
         cycle("scan");
      end

      // Directed table.
      for (int t = 0; t < 11; t++) begin
         we3 = vt[t].we3; wa3 = vt[t].wa3; wd3 = vt[t].wd3;
         we4 = vt[t].we4; wa4 = vt[t].wa4; wd4 = vt[t].wd4;
         rsv_en = vt[t].rsv; rsv_addr = vt[t].rsv_a;
         ra = {vt[t].r1, vt[t].r0};
         cycle($sformatf("tbl%0d_pre", t));
         idle();
         #1;
         for (int u = 0; u < 2; u++) begin : g_inst
            logic [NRD*W-1:0] r;
            logic [1:0]       b;
            r = (u == 0) ? rd_nb : rd_bp;
            b = (u == 0) ? busy_nb : busy_bp;
            check($sformatf("tbl%0d.%0d rd0", t, u), r[0 +: W], vt[t].e0);
            check($sformatf("tbl%0d.%0d rd1", t, u), r[W +: W], vt[t].e1);
            check($sformatf("tbl%0d.%0d busy", t, u), W'(b), W'(vt[t].eb));
         end
      end

      // Same-cycle bypass of a write: only the BYPASS=1 instance sees it early.
      @(posedge clk);
      #1;
      we3 = 1; wa3 = AW'(2); wd3 = W'(64'h22);
      set_ra(2, 25);
      #2;
      check("byp write rd nb", rd_nb[0 +: W], W'(2));
      check("byp write rd bp", rd_bp[0 +: W], W'(64'h22));
      @(posedge clk);
      model_edge();
      #1;
      idle();
      #1;
      check("byp write after edge", rd_nb[0 +: W], W'(64'h22));

      // Busy bypass on a returning load, and its suppression by a new reservation.
      rsv_en = 1; rsv_addr = AW'(12);
      cycle("rsv12");
      idle();
      we4 = 1; wa4 = AW'(12); wd4 = W'(64'h1212);
      set_ra(12, 12);
      #2;
      check("ret busy nb", W'(busy_nb[0]), W'(1));
      check("ret busy bp", W'(busy_bp[0]), W'(0));
      rsv_en = 1; rsv_addr = AW'(12);
      #1;
      check("ret+rsv busy bp", W'(busy_bp[1]), W'(1));
      @(posedge clk);
      model_edge();
      #1;
      idle();
      #1;
      check("ret+rsv busy after", W'(busy_nb[0]), W'(1));
      check_all("ret+rsv");

      // Reservations aborted by an asynchronous reset between edges.
      @(posedge clk);
      #1;
      we3 = 1; wa3 = AW'(3); wd3 = W'(64'h333);
      rsv_en = 1; rsv_addr = AW'(3);
      cycle("rsv3");
      idle();
      rsv_en = 1; rsv_addr = AW'(9);
      cycle("rsv9");
      idle();
      set_ra(3, 9);
      #2;
      check("pre-reset busy", W'(busy_nb), W'(2'b11));
      check("pre-reset rd3", rd_nb[0 +: W], W'(64'h333));
      reset = 1'b1;
      model_reset();
      #1;
      check("reset busy nb", W'(busy_nb), W'(0));
      check("reset busy bp", W'(busy_bp), W'(0));
      check("reset rd3", rd_nb[0 +: W], W'(3));
      check("reset rd9", rd_nb[W +: W], W'(9));
      check_all("reset_mid");
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Random traffic against the model.
      for (int n = 0; n < 400; n++) begin
         we3 = 1'($urandom_range(0, 1));
         wa3 = AW'(rnd_addr());
         wd3 = {$urandom, $urandom};
         we4 = 1'($urandom_range(0, 1));
         wa4 = AW'(rnd_addr());
         wd4 = {$urandom, $urandom};
         rsv_en = 1'($urandom_range(0, 2) == 0);
         rsv_addr = AW'(rnd_addr());
         set_ra(rnd_addr(), rnd_addr());
         cycle("rnd");
      end
      idle();
      #2;
      check_all("final");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
